buffer_tra_deframe: RTL and testbench
=====================================

# buffer_tra_deframe

Receive-side deframer for the 10-bit symbol stream produced by the MOPSHUB SPI/e-link framing buffer. Each frame is comma fill, an SOP K-character, four data bytes (MSB first), optional comma fill, then an EOP K-character. The block tracks frame state, assembles the four payload bytes into a 32-bit word, and presents it with a single-cycle valid strobe on a correct EOP. Malformed framing raises a one-cycle error pulse. It sits between the symbol source (SPI shift-in or e-link decoder) and the CAN/MOPS message buffer.

## Interface
Parameters:
- TIMEOUT_SYMS, 16, maximum valid symbols accepted after SOP before EOP; used only with DEFRAME_TIMEOUT_EN; range 6..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_in_10bit  input  10  symbol: [9:8] type (11 comma, 10 SOP, 01 EOP, 00 data), [7:0] value.
- data_in_valid  input  1  symbol strobe; symbol sampled only when high.
- Kchar_sop  input  8  expected SOP K-character value.
- Kchar_eop  input  8  expected EOP K-character value.
- Kchar_comma  input  8  expected comma K-character value.
- data_rec_32bitout  output  32  assembled payload; first data byte in [31:24], last in [7:0].
- data_rec_valid  output  1  one-cycle pulse; payload valid.
- frame_err  output  1  one-cycle pulse on any framing violation.
- busy  output  1  high while a frame is open (state not IDLE).

## Operation
- Symbol classes: COMMA = {11,Kchar_comma}; SOP = {10,Kchar_sop}; EOP = {01,Kchar_eop}; DATA = {00,x}. A K-type code whose value does not match its expected character is BADK.
- States: IDLE, DATA, WAIT_EOP. A 2-bit byte counter (byte_cnt) and a 32-bit shift register (asm_reg) are internal.
- IDLE:
  - COMMA: ignored.
  - SOP: go to DATA, byte_cnt=0.
  - DATA, EOP or BADK: frame_err, stay in IDLE.
- DATA:
  - DATA symbol: write the byte into asm_reg at position byte_cnt (0→[31:24] … 3→[7:0]) and increment byte_cnt. On byte_cnt==3, go to WAIT_EOP.
  - COMMA: ignored; counter holds.
  - SOP: frame_err; restart DATA with byte_cnt=0.
  - EOP (early) or BADK: frame_err; go to IDLE.
- WAIT_EOP:
  - COMMA: ignored.
  - EOP: load data_rec_32bitout from asm_reg, pulse data_rec_valid, go to IDLE.
  - DATA or BADK: frame_err; go to IDLE.
  - SOP: frame_err; go to DATA with byte_cnt=0.
- data_rec_32bitout changes only on a good EOP. Partial frames are never visible on it, and it holds until the next good frame.
- data_in_valid low: no state, counter or register change.
- Kchar_* are quasi-static. Changing them mid-frame is allowed; the new values apply from the next sampled symbol.

## Timing
- Reset values: data_rec_32bitout=0, data_rec_valid=0, frame_err=0, busy=0, state IDLE, byte_cnt=0, asm_reg=0.
- Reset asserted mid-frame discards the partial frame immediately (asynchronous). No valid or error pulse is produced.
- All outputs are registered.
- data_rec_valid and frame_err assert in the cycle after the clock edge that samples the deciding symbol, for exactly one cycle.
- busy is registered state decode. It rises the cycle after SOP is sampled and falls the cycle after EOP or an aborting symbol is sampled.
- Throughput: one symbol per clock. Back-to-back frames are supported: EOP followed immediately by SOP on the next cycle.
- data_rec_valid and frame_err are never high in the same cycle.

## Configuration
- DEFRAME_TIMEOUT_EN defined:
  - An 8-bit symbol counter clears on SOP and increments on every valid symbol sampled in DATA or WAIT_EOP.
  - If the counter reaches TIMEOUT_SYMS without an EOP: frame_err pulses, state returns to IDLE, and no payload is output.
  - An EOP sampled on the same symbol that reaches the limit is accepted.
- DEFRAME_TIMEOUT_EN undefined: no counter is built; the block waits for EOP indefinitely.

## Test plan
- Nominal frame: comma, SOP, 0xDE, 0xAD, 0xBE, 0xEF, six commas, EOP -> data_rec_32bitout=0xDEADBEEF, data_rec_valid high for 1 cycle after EOP, busy high from SOP+1 to EOP+1, frame_err stays 0.
- Back-to-back: frame 0x01020304 EOP, then SOP next cycle, then frame 0xA5A55A5A -> two valid pulses carrying the correct words; output holds 0x01020304 between them.
- Early EOP: SOP, 0x11, 0x22, EOP -> frame_err pulse, no valid pulse, output keeps its previous value, state IDLE.
- Errors: DATA symbol in IDLE -> frame_err. SOP in WAIT_EOP -> frame_err, and a following 4 bytes plus EOP still deliver the new word. {10,0x00} with Kchar_sop=0x3C -> frame_err.
- Reset mid-frame: SOP, 0xAA, 0xBB, then assert rst, release, then full frame 0x12345678 -> only 0x12345678 is output; outputs are 0 during reset.
- With DEFRAME_TIMEOUT_EN, TIMEOUT_SYMS=16: SOP, 4 bytes, then 20 commas -> frame_err after the 16th symbol following SOP, no valid pulse. Without the macro -> no error, and a late EOP delivers the word.

Source files
------------

// File: rtl/buffer_tra_deframe.sv
// ============================================================================
// buffer_tra_deframe : receive-side deframer for 10-bit SOP/data/EOP symbols.
// Optional symbol timeout: define DEFRAME_TIMEOUT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module buffer_tra_deframe #(
   parameter int TIMEOUT_SYMS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  data_in_10bit,
   input  logic        data_in_valid,
   input  logic [7:0]  Kchar_sop,
   input  logic [7:0]  Kchar_eop,
   input  logic [7:0]  Kchar_comma,
   output logic [31:0] data_rec_32bitout,
   output logic        data_rec_valid,
   output logic        frame_err,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DATA     = 2'd1,
      S_WAIT_EOP = 2'd2
   } state_t;

   state_t      r_state;
   logic [1:0]  r_byte_cnt;
   logic [31:0] r_asm;
   logic [31:0] r_data_out;
   logic        r_valid;
   logic        r_err;

   logic [1:0]  w_typ;
   logic [7:0]  w_val;
   logic        w_is_comma;
   logic        w_is_sop;
   logic        w_is_eop;
   logic        w_is_data;
   logic        w_continue;
   logic        w_timeout;

   if (TIMEOUT_SYMS < 6 || TIMEOUT_SYMS > 255) begin : g_timeout_range_chk
      $error("TIMEOUT_SYMS must be within 6..255");
   end

   assign w_typ      = data_in_10bit[9:8];
   assign w_val      = data_in_10bit[7:0];
   assign w_is_comma = (w_typ == 2'b11) && (w_val == Kchar_comma);
   assign w_is_sop   = (w_typ == 2'b10) && (w_val == Kchar_sop);
   assign w_is_eop   = (w_typ == 2'b01) && (w_val == Kchar_eop);
   assign w_is_data  = (w_typ == 2'b00);

   // Symbols that would leave the frame open; only these can trip the timeout,
   // so an EOP or an aborting symbol at the limit keeps its own meaning.
   assign w_continue = ((r_state == S_DATA) && (w_is_comma || w_is_data)) ||
                       ((r_state == S_WAIT_EOP) && w_is_comma);

`ifdef DEFRAME_TIMEOUT_EN
   logic [7:0] r_sym_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sym_cnt <= 8'd0;
      end else if (data_in_valid) begin
         if (w_is_sop)
            r_sym_cnt <= 8'd0;
         else if (r_state != S_IDLE)
            r_sym_cnt <= r_sym_cnt + 8'd1;
      end
   end

   assign w_timeout = data_in_valid && w_continue &&
                      (r_sym_cnt == 8'(TIMEOUT_SYMS - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_byte_cnt <= 2'd0;
         r_asm      <= 32'd0;
         r_data_out <= 32'd0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         if (data_in_valid) begin
            case (r_state)
               S_IDLE: begin
                  if (w_is_sop) begin
                     r_state    <= S_DATA;
                     r_byte_cnt <= 2'd0;
                  end else if (!w_is_comma) begin
                     r_err <= 1'b1;
                  end
               end
               S_DATA: begin
                  if (w_is_data) begin
                     case (r_byte_cnt)
                        2'd0:    r_asm[31:24] <= w_val;
                        2'd1:    r_asm[23:16] <= w_val;
                        2'd2:    r_asm[15:8]  <= w_val;
                        default: r_asm[7:0]   <= w_val;
                     endcase
                     r_byte_cnt <= r_byte_cnt + 2'd1;
                     if (r_byte_cnt == 2'd3)
                        r_state <= S_WAIT_EOP;
                  end else if (w_is_sop) begin
                     r_err      <= 1'b1;
                     r_byte_cnt <= 2'd0;
                  end else if (!w_is_comma) begin
                     r_err   <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end
               S_WAIT_EOP: begin
                  if (w_is_eop) begin
                     r_data_out <= r_asm;
                     r_valid    <= 1'b1;
                     r_state    <= S_IDLE;
                  end else if (w_is_sop) begin
                     r_err      <= 1'b1;
                     r_state    <= S_DATA;
                     r_byte_cnt <= 2'd0;
                  end else if (!w_is_comma) begin
                     r_err   <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
            if (w_timeout) begin
               r_err   <= 1'b1;
               r_state <= S_IDLE;
            end
         end
      end
   end

   assign data_rec_32bitout = r_data_out;
   assign data_rec_valid    = r_valid;
   assign frame_err         = r_err;
   assign busy              = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_buffer_tra_deframe.sv
// ============================================================================
// tb_buffer_tra_deframe : scoreboard bench for buffer_tra_deframe.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_buffer_tra_deframe;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [9:0]  data_in_10bit = 10'h0;
   logic        data_in_valid = 1'b0;
   logic [7:0]  Kchar_sop   = 8'h3C;
   logic [7:0]  Kchar_eop   = 8'h5C;
   logic [7:0]  Kchar_comma = 8'hBC;
   logic [31:0] data_rec_32bitout;
   logic        data_rec_valid;
   logic        frame_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // bit 32 set = expected frame_err pulse, else expected valid word
   logic [32:0] exp_q[$];

   buffer_tra_deframe #(.TIMEOUT_SYMS(16)) dut (
      .clk              (clk),
      .rst              (rst),
      .data_in_10bit    (data_in_10bit),
      .data_in_valid    (data_in_valid),
      .Kchar_sop        (Kchar_sop),
      .Kchar_eop        (Kchar_eop),
      .Kchar_comma      (Kchar_comma),
      .data_rec_32bitout(data_rec_32bitout),
      .data_rec_valid   (data_rec_valid),
      .frame_err        (frame_err),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [9:0] comma_s(); return {2'b11, Kchar_comma}; endfunction
   function automatic logic [9:0] sop_s();   return {2'b10, Kchar_sop};   endfunction
   function automatic logic [9:0] eop_s();   return {2'b01, Kchar_eop};   endfunction

   task automatic send(input logic [9:0] s);
      @(negedge clk);
      data_in_10bit = s;
      data_in_valid = 1'b1;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge clk);
         data_in_valid = 1'b0;
         data_in_10bit = 10'h0FF;
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      send({2'b00, w[31:24]});
      send({2'b00, w[23:16]});
      send({2'b00, w[15:8]});
      send({2'b00, w[7:0]});
   endtask

   task automatic push_word(input logic [31:0] w); exp_q.push_back({1'b0, w}); endtask
   task automatic push_err(); exp_q.push_back({1'b1, 32'h0}); endtask

   // Monitor: every output pulse must match the oldest expected event.
   initial begin
      forever begin
         @(negedge clk);
         if (rst && (data_rec_valid || frame_err)) begin
            if (data_rec_valid && frame_err) begin
               chk("valid_err_overlap", 33'd1, 33'd0);
            end else if (exp_q.size() == 0) begin
               chk("unexpected_pulse", {frame_err, data_rec_32bitout}, 33'h1_FFFF_FFFF);
            end else begin
               chk("scoreboard_event",
                   {frame_err, (data_rec_valid ? data_rec_32bitout : 32'h0)},
                   exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_out",   {1'b0, data_rec_32bitout}, 33'h0);
      chk("reset_valid", {32'h0, data_rec_valid}, 33'h0);
      chk("reset_err",   {32'h0, frame_err}, 33'h0);
      chk("reset_busy",  {32'h0, busy}, 33'h0);
      rst = 1'b1;

      // Nominal frame
      send(comma_s());
      send(sop_s());
      send(10'h0DE);
      chk("busy_after_sop", {32'h0, busy}, 33'h1);
      send(10'h0AD); send(10'h0BE); send(10'h0EF);
      repeat (6) send(comma_s());
      push_word(32'hDEADBEEF);
      send(eop_s());
      send(comma_s());
      chk("busy_after_eop", {32'h0, busy}, 33'h0);
      chk("nominal_word", {1'b0, data_rec_32bitout}, {1'b0, 32'hDEADBEEF});

      // Back-to-back frames
      send(sop_s());
      send_word(32'h01020304);
      push_word(32'h01020304);
      send(eop_s());
      send(sop_s());
      send(10'h0A5);
      chk("hold_between", {1'b0, data_rec_32bitout}, {1'b0, 32'h01020304});
      send(10'h0A5); send(10'h05A); send(10'h05A);
      push_word(32'hA5A55A5A);
      send(eop_s());
      send(comma_s());

      // Early EOP
      send(sop_s());
      send(10'h011); send(10'h022);
      push_err();
      send(eop_s());
      send(comma_s());
      chk("early_eop_hold", {1'b0, data_rec_32bitout}, {1'b0, 32'hA5A55A5A});
      chk("early_eop_idle", {32'h0, busy}, 33'h0);

      // DATA symbol in IDLE
      push_err();
      send(10'h077);

      // SOP in WAIT_EOP, then the new frame still delivers
      send(sop_s());
      send_word(32'h99887766);
      push_err();
      send(sop_s());
      send_word(32'hCAFEF00D);
      push_word(32'hCAFEF00D);
      send(eop_s());

      // Bad K character: SOP type with wrong value
      push_err();
      send({2'b10, 8'h00});

      // Gaps with data_in_valid low must not disturb an open frame
      send(sop_s());
      send(10'h0C1);
      gap(3);
      send(10'h0C2); send(10'h0C3);
      gap(2);
      send(10'h0C4);
      push_word(32'hC1C2C3C4);
      send(eop_s());
      send(comma_s());

      // Reset mid-frame
      send(sop_s());
      send(10'h0AA); send(10'h0BB);
      @(posedge clk);
      #2;
      data_in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("midreset_out",  {1'b0, data_rec_32bitout}, 33'h0);
      chk("midreset_busy", {32'h0, busy}, 33'h0);
      @(negedge clk);
      rst = 1'b1;
      send(sop_s());
      send_word(32'h12345678);
      push_word(32'h12345678);
      send(eop_s());
      send(comma_s());
      chk("after_reset_word", {1'b0, data_rec_32bitout}, {1'b0, 32'h12345678});

      // Long comma run after the payload
      send(sop_s());
      send_word(32'h0BADF00D);
`ifdef DEFRAME_TIMEOUT_EN
      repeat (11) send(comma_s());
      push_err();
      send(comma_s());
      repeat (8) send(comma_s());
      push_err();
      send(eop_s());
      send(comma_s());
      chk("timeout_hold", {1'b0, data_rec_32bitout}, {1'b0, 32'h12345678});
`else
      repeat (20) send(comma_s());
      push_word(32'h0BADF00D);
      send(eop_s());
      send(comma_s());
      chk("late_eop_word", {1'b0, data_rec_32bitout}, {1'b0, 32'h0BADF00D});
`endif

      gap(4);
      chk("scoreboard_drained", {1'b0, 32'(exp_q.size())}, 33'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
